keystream_packer: RTL and testbench

KEYSTREAM_PACKER -- requirements
Module: keystream_packer

---
 rtl/keystream_pkg.sv | 11 +
 rtl/ks_fifo2.sv | 46 ++++
 rtl/keystream_packer.sv | 97 +++++++++
 tb/tb_keystream_packer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/keystream_pkg.sv
// Shared widths and state encoding for the keystream byte packer.
package keystream_pkg;
  localparam int unsigned WORD_W     = 8;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = $clog2(WORD_W);

  typedef enum logic {
    WARMUP  = 1'b0,
    COLLECT = 1'b1
  } ks_state_e;
endpackage

// File: rtl/ks_fifo2.sv
// Two-entry synchronous FIFO; a push into a full FIFO succeeds only alongside a pop.
module ks_fifo2
  import keystream_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      if (do_push && !do_pop)      occ <= occ + OCC_W'(1);
      else if (!do_push && do_pop) occ <= occ - OCC_W'(1);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (occ == OCC_W'(FIFO_DEPTH));
  assign empty = (occ == '0);
endmodule

// File: rtl/keystream_packer.sv
// Packs qualified generator bits into bytes after a warm-up discard, buffering
// completed words in a 2-entry FIFO with a sticky drop flag.
module keystream_packer #(
  parameter int unsigned WARMUP    = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             bit_in,
  input  logic                             bit_en,
  input  logic                             flush,
  output logic [keystream_pkg::WORD_W-1:0] byte_out,
  output logic                             byte_valid,
  input  logic                             byte_ready,
  output logic                             overflow,
  output logic                             warm
);
  import keystream_pkg::*;

  localparam int unsigned DW = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

  ks_state_e         state;
  logic [DW-1:0]     disc_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] next_word;
  logic [CNT_W-1:0]  bit_cnt;
  logic              take_bit;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign take_bit  = bit_en && !flush && (state == COLLECT);
  assign next_word = MSB_FIRST ? {shreg[WORD_W-2:0], bit_in} : {bit_in, shreg[WORD_W-1:1]};
  assign push      = take_bit && (bit_cnt == CNT_W'(WORD_W - 1));
  assign pop       = byte_valid && byte_ready;
  assign byte_valid = !fifo_empty;

  // Warm-up/collect control, shift register and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= keystream_pkg::WARMUP;
      disc_cnt <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      overflow <= 1'b0;
      warm     <= 1'b0;
    end else begin
      if (flush) begin
        state    <= keystream_pkg::WARMUP;
        warm     <= 1'b0;
        disc_cnt <= '0;
        shreg    <= '0;
        bit_cnt  <= '0;
      end else begin
        case (state)
          keystream_pkg::WARMUP: begin
            if (WARMUP == 0) begin
              state <= COLLECT;
              warm  <= 1'b1;
            end else if (bit_en) begin
              if (disc_cnt == DW'(WARMUP - 1)) begin
                state    <= COLLECT;
                warm     <= 1'b1;
                disc_cnt <= '0;
              end else begin
                disc_cnt <= disc_cnt + DW'(1);
              end
            end
          end
          COLLECT: begin
            if (bit_en) begin
              shreg   <= next_word;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= keystream_pkg::WARMUP;
            warm  <= 1'b0;
          end
        endcase
      end
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  ks_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (next_word),
    .dout  (byte_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_keystream_packer.sv
// Randomized and directed bench for keystream_packer against a queue-based reference model.
module tb_keystream_packer;
  localparam int unsigned WARMUP = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_in;
  logic       bit_en;
  logic       flush;
  logic       byte_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       overflow;
  logic       warm;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_disc;
  bit         m_warm;
  bit         m_bits[$];
  logic [7:0] m_fifo[$];
  bit         m_ovf;

  // Words the DUT actually handed over
  logic [7:0] seen[$];

  always #5 clk = ~clk;

  keystream_packer #(.WARMUP(WARMUP), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .flush      (flush),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .overflow   (overflow),
    .warm       (warm)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_disc = 0;
    m_warm = 1'b0;
    m_bits.delete();
    m_fifo.delete();
    m_ovf  = 1'b0;
  endtask

  task automatic model_clk(input bit en, input bit b, input bit fl, input bit rdy);
    bit         do_pop;
    bit         do_push;
    logic [7:0] w;
    do_pop  = (m_fifo.size() != 0) && rdy;
    do_push = 1'b0;
    w       = '0;
    if (fl) begin
      m_disc = 0;
      m_warm = 1'b0;
      m_bits.delete();
    end else if (en) begin
      if (!m_warm) begin
        m_disc++;
        if (m_disc == WARMUP) begin
          m_warm = 1'b1;
          m_disc = 0;
        end
      end else begin
        m_bits.push_back(b);
        if (m_bits.size() == 8) begin
          for (int i = 0; i < 8; i++) w[7-i] = m_bits[i];
          m_bits.delete();
          do_push = 1'b1;
        end
      end
    end
    if (do_pop) void'(m_fifo.pop_front());
    if (do_push) begin
      if (m_fifo.size() < 2) m_fifo.push_back(w);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 32'(byte_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) check({tag, ".data"}, 32'(byte_out), 32'(m_fifo[0]));
    if (!rst_n) check({tag, ".rst_data"}, 32'(byte_out), 32'h0);
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".warm"}, 32'(warm), 32'(m_warm));
  endtask

  task automatic step(input bit en, input bit b, input bit fl, input bit rdy, input string tag);
    bit_en     = en;
    bit_in     = b;
    flush      = fl;
    byte_ready = rdy;
    #2;
    if (rst_n && byte_valid && byte_ready) seen.push_back(byte_out);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_clk(en, b, fl, rdy);
    #1;
    compare_all(tag);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit rdy, input string tag);
    for (int i = 0; i < 8; i++) step(1'b1, v[7-i], 1'b0, rdy, tag);
  endtask

  task automatic warmup_bits(input bit rdy, input string tag);
    for (int i = 0; i < int'(WARMUP); i++) step(1'b1, 1'b1, 1'b0, rdy, tag);
  endtask

  task automatic idle(input int n, input bit rdy, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, tag);
  endtask

  // Asynchronous reset between edges, checked before any clock arrives.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    step(1'b1, 1'b1, 1'b0, 1'b1, {tag, ".held"});
    step(1'b1, 1'b0, 1'b0, 1'b1, {tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    bit_in     = 1'b0;
    bit_en     = 1'b0;
    flush      = 1'b0;
    byte_ready = 1'b0;
    model_reset();
    #1;
    compare_all("por");
    repeat (2) @(posedge clk);
    #1;
    compare_all("por_hold");
    rst_n = 1'b1;

    // Warm-up then 0xB2, consumer always ready
    seen.delete();
    warmup_bits(1'b1, "b2_warm");
    send_byte(8'hB2, 1'b1, "b2");
    idle(3, 1'b1, "b2_idle");
    check("b2_count", 32'(seen.size()), 32'd1);
    if (seen.size() == 1) check("b2_word", 32'(seen[0]), 32'hB2);

    // bit_en toggling: warm-up and collection must ignore gaps
    seen.delete();
    step(1'b0, 1'b0, 1'b1, 1'b1, "gap_flush");
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, "gap_on");
      step(1'b0, 1'b0, 1'b0, 1'b1, "gap_off");
    end
    idle(2, 1'b1, "gap_idle");
    check("gap_count", 32'(seen.size()), 32'd1);
    if (seen.size() == 1) check("gap_word", 32'(seen[0]), 32'hFF);

    // Overflow: third word dropped, buffered words kept in order
    seen.delete();
    send_byte(8'hA5, 1'b0, "ovf_a5");
    send_byte(8'h3C, 1'b0, "ovf_3c");
    send_byte(8'h0F, 1'b0, "ovf_0f");
    check("ovf_set", 32'(overflow), 32'd1);
    idle(4, 1'b1, "ovf_drain");
    check("ovf_count", 32'(seen.size()), 32'd2);
    if (seen.size() == 2) begin
      check("ovf_w0", 32'(seen[0]), 32'hA5);
      check("ovf_w1", 32'(seen[1]), 32'h3C);
    end
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO: pop and push in the same cycle both succeed
    async_reset("rst_a");
    seen.delete();
    warmup_bits(1'b0, "pp_warm");
    send_byte(8'h11, 1'b0, "pp_11");
    send_byte(8'h22, 1'b0, "pp_22");
    for (int i = 0; i < 8; i++) step(1'b1, i != 0 && i != 7 ? 1'b0 : 1'b1, 1'b0, i == 7, "pp_81");
    idle(4, 1'b1, "pp_drain");
    check("pp_ovf", 32'(overflow), 32'd0);
    check("pp_count", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      check("pp_w0", 32'(seen[0]), 32'h11);
      check("pp_w1", 32'(seen[1]), 32'h22);
      check("pp_w2", 32'(seen[2]), 32'h81);
    end

    // Flush mid-word, coinciding with bit_en; buffered word survives
    seen.delete();
    send_byte(8'h5A, 1'b0, "fl_5a");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "fl_part");
    step(1'b1, 1'b1, 1'b1, 1'b0, "fl_flush");
    check("fl_warm", 32'(warm), 32'd0);
    warmup_bits(1'b0, "fl_rewarm");
    send_byte(8'hC3, 1'b0, "fl_c3");
    idle(4, 1'b1, "fl_drain");
    check("fl_count", 32'(seen.size()), 32'd2);
    if (seen.size() == 2) begin
      check("fl_w0", 32'(seen[0]), 32'h5A);
      check("fl_w1", 32'(seen[1]), 32'hC3);
    end

    // Reset mid-word with two buffered words
    send_byte(8'h77, 1'b0, "rs_w0");
    send_byte(8'h99, 1'b0, "rs_w1");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "rs_part");
    async_reset("rst_b");
    check("rs_valid", 32'(byte_valid), 32'd0);
    warmup_bits(1'b1, "rs_rewarm");
    check("rs_warm", 32'(warm), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) async_reset("rnd_rst");
      else step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 79) == 0,
                $urandom_range(0, 2) != 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
